// File: rtl/change_dispenser.sv
// change_dispenser: pays out an owed balance (in nickels) as dimes and nickels,
// one coin at a time, each confirmed by a coin-drop sensor with a timeout.
module change_dispenser #(
    parameter int BAL_W   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_10c,
    input  logic             i_20c,
    input  logic             hop10_empty,
    input  logic             hop5_empty,
    input  logic             coin_drop,
    input  logic             clr_err,
    output logic             hop10_req,
    output logic             hop5_req,
    output logic             busy,
    output logic             o_err,
    output logic             o_ovf,
    output logic [BAL_W-1:0] owed
);

    // One extra bit holds owed plus the largest single-cycle credit (6 nickels).
    localparam int AW    = BAL_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [AW-1:0]    BAL_MAX  = AW'((1 << BAL_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WAIT,
        S_GAP,
        S_ERR
    } state_t;

    typedef enum logic {
        COIN_NICKEL = 1'b0,
        COIN_DIME   = 1'b1
    } coin_t;

    state_t           state;
    coin_t            sel;
    logic [TMR_W-1:0] timer;

    logic [AW-1:0] add;
    logic [AW-1:0] dec;
    logic [AW-1:0] sum;
    logic [AW-1:0] nxt;

    // Clamp a widened balance back into the register range.
    function automatic logic [BAL_W-1:0] sat_bal(input logic [AW-1:0] v);
        if (v > BAL_MAX) begin
            return BAL_MAX[BAL_W-1:0];
        end
        return v[BAL_W-1:0];
    endfunction

    // True when a widened balance does not fit and will be clamped.
    function automatic logic bal_over(input logic [AW-1:0] v);
        return v > BAL_MAX;
    endfunction

    // Next balance: credits from the vending side minus a coin confirmed in WAIT.
    always_comb begin
        add = '0;
        dec = '0;
        if (i_10c) begin
            add = add + AW'(2);
        end
        if (i_20c) begin
            add = add + AW'(4);
        end
        if ((state == S_WAIT) && coin_drop) begin
            dec = (sel == COIN_DIME) ? AW'(2) : AW'(1);
        end
        sum = {1'b0, owed} + add;
        // A confirmed coin never exceeds the balance that selected it; guard anyway.
        nxt = (sum >= dec) ? (sum - dec) : '0;
    end

    // Balance register and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owed  <= '0;
            o_ovf <= 1'b0;
        end else begin
            owed <= sat_bal(nxt);
            if (bal_over(nxt)) begin
                o_ovf <= 1'b1;
            end else if (clr_err) begin
                o_ovf <= 1'b0;
            end
        end
    end

    // Payout sequencer: choose a coin, hold its request until drop or timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            sel   <= COIN_NICKEL;
            timer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (owed != '0) begin
                        state <= S_SEL;
                    end
                end
                S_SEL: begin
                    timer <= '0;
                    if ((owed >= BAL_W'(2)) && !hop10_empty) begin
                        sel   <= COIN_DIME;
                        state <= S_WAIT;
                    end else if (!hop5_empty) begin
                        sel   <= COIN_NICKEL;
                        state <= S_WAIT;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_WAIT: begin
                    if (coin_drop) begin
                        state <= S_GAP;
                    end else if (timer == TMR_LAST) begin
                        state <= S_ERR;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                S_ERR: begin
                    if (clr_err) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded purely from registered state and coin choice.
    assign hop10_req = (state == S_WAIT) && (sel == COIN_DIME);
    assign hop5_req  = (state == S_WAIT) && (sel == COIN_NICKEL);
    assign o_err     = (state == S_ERR);
    assign busy      = (state != S_IDLE) || (owed != '0);

endmodule
